// File: rtl/dmem_pkg.sv
// Shared types and constants for the writable 512x16 Q15 data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int DMEM_AW = 9;
    localparam int DMEM_DW = 16;

    // Write-side frame sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Q15 extremes, handy for saturating producers and for tests.
    localparam logic [DMEM_DW-1:0] Q15_MAX = 16'h7FFF;
    localparam logic [DMEM_DW-1:0] Q15_MIN = 16'h8000;

endpackage

// File: rtl/dmem_ram_1r1w.sv
// Simple dual-port RAM, one write port and one registered read port, read-before-write.
// Latency: read data valid one clock after the address; write takes effect at the clock edge.
// Backpressure: none; both ports accept every cycle.
//
// Ports:
//   i_clk, i_rst      clock, async active-high reset (read register only; array is not reset)
//   i_we, i_wa, i_wd  write enable / address / data
//   i_ra, o_rq        read address / registered read data
// Kept as a separate module so it can be replaced by a hard RAM macro.
module dmem_ram_1r1w
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wd,
    input  logic [AW-1:0] i_ra,
    output logic [DW-1:0] o_rq
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Non-blocking read of the array in the same edge as a write to the
    // same address returns the old contents (read-before-write).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rq <= '0;
        end else begin
            o_rq <= r_mem[i_ra];
        end
    end

endmodule

// File: rtl/dmem_wr_fp16.sv
// Captures a frame of Q15 words from a valid/ready stream into a 512x16 memory with wrapping base address.
// Latency: a word is written at the clock edge of its handshake; rd_q lags rd_a by one clock.
// Backpressure: in_ready is high only in FILL (decoded from state, never from in_valid); words offered elsewhere are dropped.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   start, base_a, frm_len         frame request (sampled in IDLE only), first address, word count 0..512
//   in_valid, in_d, in_ready       write stream handshake
//   busy, done, wr_cnt             frame in progress, one-cycle completion pulse, words written
//   rd_a, rd_q                     synchronous read port
//   cksum                          mod-2^16 frame sum, present only when DMEM_WR_CKSUM_EN is defined
module dmem_wr_fp16
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW,
    parameter int LW = DMEM_AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_a,
    input  logic [LW-1:0] frm_len,
    input  logic          in_valid,
    input  logic [DW-1:0] in_d,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] wr_cnt,
    input  logic [AW-1:0] rd_a,
    output logic [DW-1:0] rd_q
`ifdef DMEM_WR_CKSUM_EN
    ,
    output logic [DW-1:0] cksum
`endif
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_wr_cnt;
    logic [LW-1:0] w_cnt_inc;
    logic          w_start_acc;
    logic          w_hs;
    logic          w_last;
    logic          w_in_ready;
    logic          w_busy;
    logic          w_done;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_hs        = in_valid && w_in_ready;
    assign w_cnt_inc   = r_wr_cnt + LW'(1);
    assign w_last      = w_hs && (w_cnt_inc == r_len);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    // A zero-length frame completes without entering FILL.
                    w_state_nxt = (frm_len == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready = w_in_ready;
    assign busy     = w_busy;
    assign done     = w_done;
    assign wr_cnt   = r_wr_cnt;

    // Frame pointer and counters. The pointer is exactly AW bits wide so
    // the increment wraps 511 -> 0 with no extra logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_len    <= '0;
            r_wr_cnt <= '0;
        end else if (w_start_acc) begin
            r_ptr    <= base_a;
            r_len    <= frm_len;
            r_wr_cnt <= '0;
        end else if (w_hs) begin
            r_ptr    <= r_ptr + AW'(1);
            r_wr_cnt <= w_cnt_inc;
        end
    end

`ifdef DMEM_WR_CKSUM_EN
    logic [DW-1:0] r_cksum;

    // Holds its value after the last handshake, so it stays stable from
    // the done pulse until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cksum <= '0;
        end else if (w_start_acc) begin
            r_cksum <= '0;
        end else if (w_hs) begin
            r_cksum <= r_cksum + in_d;
        end
    end

    assign cksum = r_cksum;
`endif

    dmem_ram_1r1w #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .i_clk (clk),
        .i_rst (rst),
        .i_we  (w_hs),
        .i_wa  (r_ptr),
        .i_wd  (in_d),
        .i_ra  (rd_a),
        .o_rq  (rd_q)
    );

endmodule

// File: tb/tb_dmem_wr_fp16.sv
// Directed self-checking bench for dmem_wr_fp16.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: stimulus follows in_ready; in_valid gaps come from a fixed bit pattern.
module tb_dmem_wr_fp16;
    import dmem_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int LW = 10;

    localparam logic [DW-1:0] NV [20] = '{
        16'h7FFF, 16'h0C88, 16'h1897, 16'h1446, 16'h0000,
        16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
        16'h6666, 16'h7777, 16'h0123, 16'h4567, 16'h89AB,
        16'hCDEF, 16'hFEDC, 16'hBA98, 16'h8000, 16'h0000
    };

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic [AW-1:0] base_a   = '0;
    logic [LW-1:0] frm_len  = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_d     = '0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [LW-1:0] wr_cnt;
    logic [AW-1:0] rd_a     = '0;
    logic [DW-1:0] rd_q;
`ifdef DMEM_WR_CKSUM_EN
    logic [DW-1:0] cksum;
`endif

    int            n_checks = 0;
    int            n_errors = 0;
    int            done_cnt = 0;
    logic [DW-1:0] tx [512];
    logic [15:0]   gap_pat  = 16'b1011_0010_1110_0101;

    dmem_wr_fp16 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_a   (base_a),
        .frm_len  (frm_len),
        .in_valid (in_valid),
        .in_d     (in_d),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .wr_cnt   (wr_cnt),
        .rd_a     (rd_a),
        .rd_q     (rd_q)
`ifdef DMEM_WR_CKSUM_EN
        ,
        .cksum    (cksum)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int base, input int len);
        start   = 1'b1;
        base_a  = AW'(base);
        frm_len = LW'(len);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Offers tx[0..n-1]; with coll set, checks the read-before-write
    // collision at address 3 (rd_a must already be 3).
    task automatic feed(input int n, input bit gaps, input bit coll,
                        input logic [DW-1:0] old3, output int rdy_cycles);
        int idx;
        int cyc;
        bit v;
        bit r;
        bit pend;
        idx = 0; cyc = 0; pend = 1'b0; rdy_cycles = 0;
        while (idx < n && cyc < 3000) begin
            v = gaps ? gap_pat[cyc % 16] : 1'b1;
            in_valid = v;
            in_d     = tx[idx];
            r = in_ready;
            if (r) rdy_cycles++;
            @(posedge clk); #1;
            cyc++;
            if (v && r) idx++;
            if (coll && pend) begin
                chk("coll_new", rd_q, tx[3]);
                pend = 1'b0;
            end
            if (coll && v && r && idx == 4) begin
                chk("coll_old", rd_q, old3);
                pend = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (idx < n) chk("feed_timeout", idx, n);
    endtask

    task automatic finish_chk(input string tag, input int len, input int d0);
        chk({tag, "_done"},   done,     1);
        chk({tag, "_busy"},   busy,     0);
        chk({tag, "_rdy"},    in_ready, 0);
        chk({tag, "_wr_cnt"}, wr_cnt,   len);
        @(posedge clk); #1;
        chk({tag, "_done_off"}, done, 0);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [DW-1:0] exp);
        rd_a = AW'(a);
        @(posedge clk); #1;
        chk(tag, rd_q, exp);
    endtask

    initial begin
        int rdy;
        int d0;

        // Reset state
        #2;
        chk("rst_rdy",  in_ready, 0);
        chk("rst_busy", busy,     0);
        chk("rst_done", done,     0);
        chk("rst_cnt",  wr_cnt,   0);
        chk("rst_rq",   rd_q,     0);
`ifdef DMEM_WR_CKSUM_EN
        chk("rst_ck",   cksum,    0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Backpressure / gaps: len 8 at base 0
        for (int i = 0; i < 8; i++) tx[i] = 16'hB000 + 16'(i);
        d0 = done_cnt;
        start_frame(0, 8);
        chk("bp_busy", busy, 1);
        feed(8, 1'b1, 1'b0, 16'h0, rdy);
        finish_chk("bp", 8, d0);
        for (int a = 0; a < 8; a++) rd_chk("bp_rd", a, 16'hB000 + 16'(a));

        // Normal frame: base 0, len 20, with collision at address 3
        for (int i = 0; i < 20; i++) tx[i] = NV[i];
        rd_a = 9'd3;
        d0 = done_cnt;
        start_frame(0, 20);
        feed(20, 1'b0, 1'b1, 16'hB003, rdy);
        chk("norm_rdy_cycles", rdy, 20);
        finish_chk("norm", 20, d0);
        for (int a = 0; a < 20; a++) rd_chk("norm_rd", a, NV[a]);

`ifdef DMEM_WR_CKSUM_EN
        // Checksum: Q15_MAX + 1 wraps to Q15_MIN
        tx[0] = Q15_MAX;
        tx[1] = 16'h0001;
        d0 = done_cnt;
        start_frame(40, 2);
        chk("ck_clear", cksum, 0);
        feed(2, 1'b0, 1'b0, 16'h0, rdy);
        chk("ck_sum", cksum, Q15_MIN);
        finish_chk("ck", 2, d0);
        chk("ck_stable", cksum, Q15_MIN);
`endif

        // Wrap: base 500, len 20, data 0..19
        for (int i = 0; i < 20; i++) tx[i] = 16'(i);
        d0 = done_cnt;
        start_frame(500, 20);
        feed(20, 1'b0, 1'b0, 16'h0, rdy);
        finish_chk("wrap", 20, d0);
        for (int a = 500; a < 512; a++) rd_chk("wrap_hi", a, 16'(a - 500));
        for (int a = 0; a < 8; a++)     rd_chk("wrap_lo", a, 16'(a + 12));
        rd_chk("wrap_untouched", 8, NV[8]);

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        in_d     = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            chk("idle_rdy", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rd_chk("idle_nowrite", 8, NV[8]);

        // Zero-length frame
        in_valid = 1'b1;
        in_d     = 16'hDEAD;
        d0 = done_cnt;
        start_frame(8, 0);
        in_valid = 1'b0;
        finish_chk("len0", 0, d0);
        rd_chk("len0_nowrite", 8, NV[8]);

        // Full 512-word frame at base 100
        for (int i = 0; i < 512; i++) tx[i] = 16'(i * 7 + 3);
        d0 = done_cnt;
        start_frame(100, 512);
        feed(512, 1'b0, 1'b0, 16'h0, rdy);
        chk("len512_rdy_cycles", rdy, 512);
        finish_chk("len512", 512, d0);
        for (int a = 0; a < 512; a++)
            rd_chk("len512_rd", a, 16'((((a + 412) % 512) * 7) + 3));

        // Reset after 5 of 10 words
        for (int i = 0; i < 10; i++) tx[i] = 16'hC000 + 16'(i);
        start_frame(200, 10);
        feed(5, 1'b0, 1'b0, 16'h0, rdy);
        chk("mid_cnt", wr_cnt, 5);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("mid_rdy",  in_ready, 0);
        chk("mid_busy", busy,     0);
        chk("mid_done", done,     0);
        chk("mid_wcnt", wr_cnt,   0);
        chk("mid_rq",   rd_q,     0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_resume", busy, 0);
        chk("mid_no_done", done_cnt - d0, 0);
        for (int a = 0; a < 5; a++) rd_chk("mid_kept", 200 + a, 16'hC000 + 16'(a));
        rd_chk("mid_unwritten", 205, 16'(105 * 7 + 3));

        // New frame after reset
        tx[0] = 16'h1234;
        tx[1] = 16'h5678;
        d0 = done_cnt;
        start_frame(300, 2);
        feed(2, 1'b0, 1'b0, 16'h0, rdy);
        finish_chk("post", 2, d0);
        rd_chk("post_rd0", 300, 16'h1234);
        rd_chk("post_rd1", 301, 16'h5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_wr_fp16.md
Name: dmem_wr_fp16

Overview:
- Writable counterpart to the constant 512x16 Q15 data ROMs: captures a stream of 16-bit Q15 results from the FPU datapath into a 512-entry data memory.
- Exposes a synchronous read port with the same 9-bit address / 16-bit data shape, so results can be read back or fed to the next pass.
- Write side is a frame-based sequencer with a valid/ready handshake and base-address wrap.

Parameters:
- AW, 9, address width; depth = 2**AW = 512
- DW, 16, data width, Q15 two's complement
- LW, 10, frame-length width; must be AW+1 so a full 512-word frame is expressible

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a frame; sampled only in IDLE
- base_a  in  AW  first write address, latched on accepted start
- frm_len  in  LW  words in frame, latched on accepted start; legal 0..512
- in_valid  in  1  producer has a word on in_d
- in_d  in  DW  Q15 word to store
- in_ready  out  1  block accepts in_d this cycle
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse: frame complete
- wr_cnt  out  LW  words written in current or last frame
- rd_a  in  AW  read address
- rd_q  out  DW  read data, registered
- cksum  out  DW  only with DMEM_WR_CKSUM_EN: running frame checksum

Behaviour:
- Reset values: in_ready=0, busy=0, done=0, wr_cnt=0, rd_q=16'h0000, cksum=0. State returns to IDLE. Memory array is not reset; contents are undefined until written.
- FSM states: IDLE, FILL, DONE.
- IDLE -> FILL: on start. Latch base_a into the pointer ptr, latch frm_len into len, clear wr_cnt (and cksum). If frm_len==0, go IDLE -> DONE instead; no writes occur.
- FILL:
  - in_ready=1, busy=1.
  - Handshake = in_valid & in_ready.
  - On handshake: mem[ptr] <= in_d, ptr <= ptr+1 mod 512, wr_cnt <= wr_cnt+1.
  - When the handshake makes wr_cnt reach len, go FILL -> DONE. That handshake is still accepted.
- DONE: done=1 for exactly one cycle, busy=0, in_ready=0; then go to IDLE.
- in_ready is a registered function of state only. It does not depend combinationally on in_valid.
- Address wrap: ptr wraps 511 -> 0 silently. Example: base 500, len 20 writes 500..511, then 0..7.
- len==512 writes every location exactly once.
- start is ignored in FILL and DONE; no queuing.
- in_valid is ignored outside FILL; no writes occur.
- Read port: rd_q <= mem[rd_a] every cycle, 1-cycle latency, independent of the FSM.
- Read and write to the same address in one cycle: rd_q returns the OLD data (read-before-write).
- Reset asserted mid-frame: the FSM goes to IDLE immediately. Words already written remain in memory. The partial frame is not resumed and done is not pulsed.

Optional Feature:
- Macro: DMEM_WR_CKSUM_EN.
- Defined:
  - cksum is a 16-bit modulo-2^16 sum of all words accepted in the frame.
  - It is cleared on accepted start and updated on each handshake.
  - It is valid and stable from the done pulse until the next accepted start.
- Undefined: the cksum port and its logic are absent.

Decomposition:
- Shared package dmem_pkg:
  - DMEM_AW=9, DMEM_DW=16
  - state enum {IDLE, FILL, DONE}
  - Q15 constants Q15_MAX=16'h7FFF, Q15_MIN=16'h8000
- One sub-module: dmem_ram_1r1w, a 512x16 simple dual-port RAM with a synchronous read-before-write port, so it can be swapped for a macro.
- The FSM and counters stay in the top module.

Test Plan:
- Normal frame: start with base 0, len 20; stream 7FFF,0C88,1897,1446,0000,...,8000,0000 with in_valid held high. Required: in_ready high for 20 cycles, done pulses exactly once, wr_cnt=20. Reading rd_a=0..19 returns the same sequence one cycle after each address.
- Wrap: start with base 500, len 20, data 0..19. Required: addresses 500..511 hold 0..11 and addresses 0..7 hold 12..19; address 8 is untouched.
- Backpressure and gaps: toggle in_valid randomly during a len-8 frame. Required: exactly 8 writes, in order. Additionally, in IDLE with in_valid=1, in_ready=0 and memory is unchanged.
- Edge lengths:
  - len 0 -> done one cycle after start, wr_cnt=0, no writes.
  - len 512 -> all 512 locations written; wr_cnt=10'd512.
- Reset mid-frame: assert rst after 5 of 10 words. Required: all outputs at reset values immediately, words 0..4 retained, no done pulse. A new start then works normally.
- Collision and checksum: with the frame writing 16'h1446 at address 3 while rd_a=3, rd_q shows the old value, then 1446 on the next read. With DMEM_WR_CKSUM_EN, frame {7FFF,0001} gives cksum=16'h8000.
